// File: rtl/seven_segment_display.sv
// seven_segment_display: hex/decimal multi-digit 7-segment driver with sign, blanking, overflow and blink
module seven_segment_display #(
  parameter int DATA_W    = 16,
  parameter int N_DIGITS  = 5,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                  i_clock,
  input  logic                  i_RSTn,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic                  i_signed,
  input  logic                  i_lzb,
  input  logic                  i_blink,
  output logic [7*N_DIGITS-1:0] o_seg,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_ovf
);
  localparam int BW = 4 * N_DIGITS;
  localparam int IW = $clog2(DATA_W);
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  state_t state, state_n;

  logic [DATA_W-1:0]     mag;
  logic [BW-1:0]         bcd, bcd_adj, dig;
  logic [IW-1:0]         iter;
  logic                  neg, dec, lzb, sticky, ovf, ovf_r, done_r, phase;
  logic [7*N_DIGITS-1:0] disp, glyphs;
  logic [CW-1:0]         bcnt;
  int                    msd, sign_pos;

  always_ff @(posedge i_clock or negedge i_RSTn)
    if (!i_RSTn) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state == IDLE ? (i_start ? (i_mode ? CONV : LOAD) : IDLE) :
              state == CONV ? (iter == IW'(DATA_W - 1) ? LOAD : CONV) : IDLE;
    o_busy  = state != IDLE;
  end

  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < N_DIGITS; k++)
      bcd_adj[4*k+:4] = bcd[4*k+:4] >= 4'd5 ? bcd[4*k+:4] + 4'd3 : bcd[4*k+:4];
  end

  // Hex digits come straight from the magnitude; decimal ones from the finished BCD register.
  assign dig = dec ? bcd : BW'(mag);
  assign ovf = dec ? (sticky | (neg & |dig[BW-1 -: 4]))
                   : |(mag >> (neg ? 4 * (N_DIGITS - 1) : 4 * N_DIGITS));

  always_comb begin
    msd    = 0;
    glyphs = '1;
    for (int k = 0; k < N_DIGITS; k++)
      if (dig[4*k+:4] != 4'd0) msd = k;
    sign_pos = lzb ? msd + 1 : N_DIGITS - 1;
    for (int k = 0; k < N_DIGITS; k++)
      glyphs[7*k+:7] = (ovf || (neg && k == sign_pos)) ? MINUS :
                       (lzb && k > msd) ? BLANK : GLYPH[dig[4*k+:4]];
  end

  always_ff @(posedge i_clock or negedge i_RSTn)
    if (!i_RSTn) begin
      mag    <= '0;
      bcd    <= '0;
      iter   <= '0;
      neg    <= 1'b0;
      dec    <= 1'b0;
      lzb    <= 1'b0;
      sticky <= 1'b0;
      disp   <= '1;
      ovf_r  <= 1'b0;
      done_r <= 1'b0;
      o_done <= 1'b0;
      o_ovf  <= 1'b0;
      o_seg  <= '1;
    end else begin
      done_r <= state == LOAD;
      o_done <= done_r;
      o_ovf  <= ovf_r;
      o_seg  <= disp | {7*N_DIGITS{i_blink & phase}};
      if (state == IDLE && i_start) begin
        neg    <= i_signed & i_data[DATA_W-1];
        mag    <= (i_signed & i_data[DATA_W-1]) ? -i_data : i_data;
        dec    <= i_mode;
        lzb    <= i_lzb;
        bcd    <= '0;
        iter   <= '0;
        sticky <= 1'b0;
      end else if (state == CONV) begin
        sticky     <= sticky | bcd_adj[BW-1];
        {bcd, mag} <= {bcd_adj[BW-2:0], mag, 1'b0};
        iter       <= iter + 1'b1;
      end else if (state == LOAD) begin
        disp  <= glyphs;
        ovf_r <= ovf;
      end
    end

  always_ff @(posedge i_clock or negedge i_RSTn)
    if (!i_RSTn) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == CW'(BLINK_DIV - 1)) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else bcnt <= bcnt + 1'b1;
endmodule

// File: tb/tb_seven_segment_display.sv
// tb_seven_segment_display: randomized and directed checks against a divide-by-base display model
module tb_seven_segment_display;
  localparam int DW = 16;
  localparam int ND = 5;
  localparam int BD = 4;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;
  localparam logic [6:0] G [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic i_start = 1'b0, i_mode = 1'b0, i_signed = 1'b0, i_lzb = 1'b0, i_blink = 1'b0;
  logic [7*ND-1:0] o_seg;
  logic o_busy, o_done, o_ovf;
  int pass_cnt = 0, total = 0;

  always #5 clk = ~clk;

  seven_segment_display #(.DATA_W(DW), .N_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .i_clock(clk), .i_RSTn(rst_n), .i_data(i_data), .i_start(i_start), .i_mode(i_mode),
    .i_signed(i_signed), .i_lzb(i_lzb), .i_blink(i_blink),
    .o_seg(o_seg), .o_busy(o_busy), .o_done(o_done), .o_ovf(o_ovf));

  // Returns {ovf, segments}: digits by repeated division, overflow when magnitude >= base^available
  function automatic logic [7*ND:0] model(input logic [DW-1:0] d, input logic m, s, l);
    longint v, t, base, lim;
    int dg [ND];
    int msd, sp;
    logic neg, ov;
    logic [7*ND-1:0] seg;
    neg  = s & d[DW-1];
    v    = neg ? (longint'(1) << DW) - longint'(d) : longint'(d);
    base = m ? 10 : 16;
    lim  = 1;
    for (int k = 0; k < (neg ? ND - 1 : ND); k++) lim *= base;
    ov  = v >= lim;
    t   = v;
    msd = 0;
    for (int k = 0; k < ND; k++) begin
      dg[k] = int'(t % base);
      t     = t / base;
      if (dg[k] != 0) msd = k;
    end
    sp = l ? msd + 1 : ND - 1;
    for (int k = 0; k < ND; k++)
      seg[7*k+:7] = ov ? MI : (neg && k == sp) ? MI : (l && k > msd) ? BL : G[dg[k]];
    return {ov, seg};
  endfunction

  task automatic convert(input logic [DW-1:0] d, input logic m, s, l, output int lat, output int busy);
    @(negedge clk);
    i_data = d; i_mode = m; i_signed = s; i_lzb = l; i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    lat  = -1;
    busy = int'(o_busy);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (o_done) begin lat = c; break; end
      busy += int'(o_busy);
    end
  endtask

  task automatic test_reset;
    total++; if (o_seg !== '1) $display("FAIL reset_seg: got %h expected %h", o_seg, {7*ND{1'b1}}); else pass_cnt++;
    total++; if ({o_busy, o_done, o_ovf} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {o_busy, o_done, o_ovf}); else pass_cnt++;
  endtask

  task automatic test_hex;
    int lat, busy;
    convert(16'h00A5, 1'b0, 1'b0, 1'b1, lat, busy);
    total++; if ({o_ovf, o_seg} !== {1'b0, BL, BL, BL, G[10], G[5]}) $display("FAIL hex_a5: got %h expected %h", {o_ovf, o_seg}, {1'b0, BL, BL, BL, G[10], G[5]}); else pass_cnt++;
    total++; if (lat !== 2) $display("FAIL hex_latency: got %0d expected 2", lat); else pass_cnt++;
    total++; if (busy !== 1) $display("FAIL hex_busy_cycles: got %0d expected 1", busy); else pass_cnt++;
    @(posedge clk); #1;
    total++; if (o_done !== 1'b0) $display("FAIL hex_done_pulse: got %b expected 0", o_done); else pass_cnt++;
    convert(16'hBEEF, 1'b0, 1'b0, 1'b0, lat, busy);
    total++; if ({o_ovf, o_seg} !== {1'b0, G[0], G[11], G[14], G[14], G[15]}) $display("FAIL hex_beef: got %h expected %h", {o_ovf, o_seg}, {1'b0, G[0], G[11], G[14], G[14], G[15]}); else pass_cnt++;
  endtask

  task automatic test_decimal;
    int lat, busy;
    convert(16'd12345, 1'b1, 1'b0, 1'b0, lat, busy);
    total++; if ({o_ovf, o_seg} !== {1'b0, G[1], G[2], G[3], G[4], G[5]}) $display("FAIL dec_12345: got %h expected %h", {o_ovf, o_seg}, {1'b0, G[1], G[2], G[3], G[4], G[5]}); else pass_cnt++;
    total++; if (lat !== DW + 2) $display("FAIL dec_latency: got %0d expected %0d", lat, DW + 2); else pass_cnt++;
    total++; if (busy !== DW + 1) $display("FAIL dec_busy_cycles: got %0d expected %0d", busy, DW + 1); else pass_cnt++;
    convert(16'd0, 1'b1, 1'b0, 1'b1, lat, busy);
    total++; if (o_seg !== {BL, BL, BL, BL, G[0]}) $display("FAIL dec_zero_lzb: got %h expected %h", o_seg, {BL, BL, BL, BL, G[0]}); else pass_cnt++;
    convert(16'd0, 1'b1, 1'b0, 1'b0, lat, busy);
    total++; if (o_seg !== {G[0], G[0], G[0], G[0], G[0]}) $display("FAIL dec_zero: got %h expected %h", o_seg, {G[0], G[0], G[0], G[0], G[0]}); else pass_cnt++;
  endtask

  task automatic test_signed;
    int lat, busy;
    convert(16'hFFF6, 1'b1, 1'b1, 1'b1, lat, busy);
    total++; if ({o_ovf, o_seg} !== {1'b0, BL, BL, MI, G[1], G[0]}) $display("FAIL sdec_lzb: got %h expected %h", {o_ovf, o_seg}, {1'b0, BL, BL, MI, G[1], G[0]}); else pass_cnt++;
    convert(16'hFFF6, 1'b1, 1'b1, 1'b0, lat, busy);
    total++; if ({o_ovf, o_seg} !== {1'b0, MI, G[0], G[0], G[1], G[0]}) $display("FAIL sdec_nolzb: got %h expected %h", {o_ovf, o_seg}, {1'b0, MI, G[0], G[0], G[1], G[0]}); else pass_cnt++;
  endtask

  task automatic test_overflow;
    int lat, busy;
    convert(16'h8000, 1'b1, 1'b1, 1'b1, lat, busy);
    total++; if ({o_ovf, o_seg} !== {1'b1, MI, MI, MI, MI, MI}) $display("FAIL ovf_dec_min: got %h expected %h", {o_ovf, o_seg}, {1'b1, MI, MI, MI, MI, MI}); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total++; if (o_ovf !== 1'b1) $display("FAIL ovf_hold: got %b expected 1", o_ovf); else pass_cnt++;
    convert(16'd65535, 1'b1, 1'b0, 1'b1, lat, busy);
    total++; if ({o_ovf, o_seg} !== {1'b0, G[6], G[5], G[5], G[3], G[5]}) $display("FAIL dec_65535: got %h expected %h", {o_ovf, o_seg}, {1'b0, G[6], G[5], G[5], G[3], G[5]}); else pass_cnt++;
    convert(16'h8000, 1'b0, 1'b1, 1'b1, lat, busy);
    total++; if ({o_ovf, o_seg} !== model(16'h8000, 1'b0, 1'b1, 1'b1)) $display("FAIL hex_signed_min: got %h expected %h", {o_ovf, o_seg}, model(16'h8000, 1'b0, 1'b1, 1'b1)); else pass_cnt++;
    convert(16'hD8F0, 1'b1, 1'b1, 1'b1, lat, busy);
    total++; if ({o_ovf, o_seg} !== model(16'hD8F0, 1'b1, 1'b1, 1'b1)) $display("FAIL dec_signed_big: got %h expected %h", {o_ovf, o_seg}, model(16'hD8F0, 1'b1, 1'b1, 1'b1)); else pass_cnt++;
  endtask

  task automatic test_random;
    int lat, busy;
    logic [DW-1:0] d;
    logic m, s, l;
    for (int i = 0; i < 40; i++) begin
      d = DW'($urandom);
      if (i % 4 == 0) d = d >> $urandom_range(15, 4);
      m = 1'($urandom); s = 1'($urandom); l = 1'($urandom);
      convert(d, m, s, l, lat, busy);
      total++; if ({o_ovf, o_seg} !== model(d, m, s, l)) $display("FAIL rand_%0d d=%h m=%b s=%b l=%b: got %h expected %h", i, d, m, s, l, {o_ovf, o_seg}, model(d, m, s, l)); else pass_cnt++;
      total++; if (lat !== (m ? DW + 2 : 2)) $display("FAIL rand_lat_%0d: got %0d expected %0d", i, lat, m ? DW + 2 : 2); else pass_cnt++;
    end
  endtask

  task automatic test_blink;
    int lat, busy, j;
    logic hid [24];
    logic [7*ND-1:0] shown;
    logic found;
    shown = {G[1], G[2], G[3], G[4], G[5]};
    convert(16'd12345, 1'b1, 1'b0, 1'b0, lat, busy);
    @(negedge clk) i_blink = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      hid[i] = o_seg === '1;
      total++; if (o_seg !== shown && o_seg !== '1) $display("FAIL blink_value_%0d: got %h expected %h or blank", i, o_seg, shown); else pass_cnt++;
    end
    j = -1;
    for (int i = 23; i >= 1; i--) if (hid[i] != hid[i-1]) j = i;
    total++; if (j < 1 || j > BD) $display("FAIL blink_first_toggle: got %0d expected 1..%0d", j, BD); else pass_cnt++;
    if (j >= 1)
      for (int i = j + 1; i < 24; i++) begin
        total++; if (hid[i] !== (hid[j] ^ 1'(((i - j) / BD) % 2))) $display("FAIL blink_phase_%0d: got %b expected %b", i, hid[i], hid[j] ^ 1'(((i - j) / BD) % 2)); else pass_cnt++;
      end
    found = 1'b0;
    for (int i = 0; i < 2 * BD + 2 && !found; i++) begin
      @(posedge clk); #1;
      found = o_seg === '1;
    end
    total++; if (!found) $display("FAIL blink_hidden_seen: got 0 expected 1"); else pass_cnt++;
    @(negedge clk) i_blink = 1'b0;
    @(posedge clk); #1;
    total++; if (o_seg !== shown) $display("FAIL blink_clear: got %h expected %h", o_seg, shown); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int dones;
    @(negedge clk);
    i_data = 16'd12345; i_mode = 1'b1; i_signed = 1'b0; i_lzb = 1'b0; i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_data = 16'h0999; i_mode = 1'b0; i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      dones += int'(o_done);
    end
    total++; if (dones !== 1) $display("FAIL b2b_done_count: got %0d expected 1", dones); else pass_cnt++;
    total++; if (o_seg !== {G[1], G[2], G[3], G[4], G[5]}) $display("FAIL b2b_value: got %h expected %h", o_seg, {G[1], G[2], G[3], G[4], G[5]}); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    int lat, busy;
    convert(16'h8000, 1'b1, 1'b1, 1'b0, lat, busy);
    total++; if (o_ovf !== 1'b1) $display("FAIL areset_pre_ovf: got %b expected 1", o_ovf); else pass_cnt++;
    @(negedge clk);
    i_data = 16'd12345; i_mode = 1'b1; i_signed = 1'b0; i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++; if (o_seg !== '1) $display("FAIL areset_seg: got %h expected all ones", o_seg); else pass_cnt++;
    total++; if ({o_busy, o_ovf, o_done} !== 3'b000) $display("FAIL areset_flags: got %b expected 000", {o_busy, o_ovf, o_done}); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    convert(16'd4321, 1'b1, 1'b0, 1'b1, lat, busy);
    total++; if ({o_ovf, o_seg} !== {1'b0, BL, G[4], G[3], G[2], G[1]}) $display("FAIL areset_after: got %h expected %h", {o_ovf, o_seg}, {1'b0, BL, G[4], G[3], G[2], G[1]}); else pass_cnt++;
    total++; if (lat !== DW + 2) $display("FAIL areset_after_lat: got %0d expected %0d", lat, DW + 2); else pass_cnt++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk) rst_n = 1'b1;
    test_hex;
    test_decimal;
    test_signed;
    test_overflow;
    test_random;
    test_blink;
    test_back_to_back;
    test_async_reset;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
